lsu_tagdp_par: RTL and testbench

- Parametrised D-cache tag read datapath for the LSU; succeeds the fixed 4-way tag datapath.
- Selects one of WAYS tag/valid reads and runs per-way parity checks over a two-stage m->g pipeline.
- Adds a sticky parity-error log with a saturating error counter.
- Adds a request/acknowledge diagnostic read port that returns registered 64-bit data in w2.

---
 rtl/lsu_tagdp_par.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_tagdp_par.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_tagdp_par.sv
// D-cache tag read datapath: way select, per-way parity check across the
// m->g pipeline, sticky parity-error log with saturating counter, and a
// request/ack diagnostic read port with registered 64-bit data.
//
// Error FSM:
//   state    | meaning
//   E_CLEAN  | no error captured since reset / last err_clr
//   E_LOGGED | way and {parity, tag} of the first error are held
//
// Diagnostic FSM:
//   state    | meaning
//   D_IDLE   | waiting for diag_req
//   D_MUX    | request accepted, sampling the selected g-stage source
//   D_ACK    | diag_ack high, diag_rdata valid
module lsu_tagdp_par #(
  parameter int WAYS = 4,
  parameter int TAGW = 29,
  parameter int PGRP = 8,
  parameter int CNTW = 8,
  localparam int WAYW = $clog2(WAYS)
) (
  input  logic                     rclk,
  input  logic                     arst_l,
  input  logic [WAYS*(TAGW+1)-1:0] dtag_rdata_m,
  input  logic [WAYS-1:0]          dva_vld_m,
  input  logic [WAYS-1:0]          lsu_dtag_rsel_m,
  input  logic                     tag_rd_vld_m,
  input  logic                     err_clr,
  input  logic                     diag_req,
  input  logic [1:0]               diag_sel,
  output logic                     diag_busy,
  output logic                     diag_ack,
  output logic [63:0]              diag_rdata,
  output logic [WAYS-1:0]          lsu_rd_dtag_parity_g,
  output logic                     tag_perr_vld,
  output logic                     tag_perr_multi,
  output logic [WAYW-1:0]          tag_perr_way
);

  localparam int NGRP = (TAGW + PGRP - 1) / PGRP;
  localparam int ENTW = TAGW + 1;

  typedef enum logic {E_CLEAN, E_LOGGED} err_st_e;
  typedef enum logic [1:0] {D_IDLE, D_MUX, D_ACK} diag_st_e;

  logic [WAYS-1:0][NGRP-1:0] grp_par_d, grp_par_q;
  logic [WAYS-1:0][TAGW-1:0] tag_d, tag_q;
  logic [WAYS-1:0]           par_d, par_q, vld_q;
  logic                      rd_vld_q;
  logic [TAGW-1:0]           sel_tag_d, sel_tag_q;
  logic                      sel_par_d, sel_par_q, sel_vld_d, sel_vld_q;

  logic [WAYS-1:0]  perr;
  logic             any_err, multi_err;
  logic [WAYW-1:0]  first_way;
  logic [TAGW:0]    first_ptag;

  err_st_e          est_q, est_d;
  logic             multi_q, multi_d;
  logic [WAYW-1:0]  way_q, way_d;
  logic [TAGW:0]    ptag_q, ptag_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  diag_st_e         dst_q, dst_d;
  logic [1:0]       dsel_q, dsel_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [63:0]      diag_src;

  // m stage: grouped parity pre-reduction per way and AND-OR way select
  always_comb begin
    grp_par_d = '0;
    tag_d     = '0;
    par_d     = '0;
    sel_tag_d = '0;
    sel_par_d = 1'b0;
    sel_vld_d = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      tag_d[w] = dtag_rdata_m[w*ENTW +: TAGW];
      par_d[w] = dtag_rdata_m[w*ENTW + TAGW];
      for (int b = 0; b < TAGW; b++) begin
        grp_par_d[w][b/PGRP] = grp_par_d[w][b/PGRP] ^ dtag_rdata_m[w*ENTW + b];
      end
      sel_tag_d = sel_tag_d | ({TAGW{lsu_dtag_rsel_m[w]}} & tag_d[w]);
      sel_par_d = sel_par_d | (lsu_dtag_rsel_m[w] & par_d[w]);
      sel_vld_d = sel_vld_d | (lsu_dtag_rsel_m[w] & dva_vld_m[w]);
    end
  end

  // m->g pipeline registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      grp_par_q <= '0;
      tag_q     <= '0;
      par_q     <= '0;
      vld_q     <= '0;
      rd_vld_q  <= 1'b0;
      sel_tag_q <= '0;
      sel_par_q <= 1'b0;
      sel_vld_q <= 1'b0;
    end else begin
      grp_par_q <= grp_par_d;
      tag_q     <= tag_d;
      par_q     <= par_d;
      vld_q     <= dva_vld_m;
      rd_vld_q  <= tag_rd_vld_m;
      sel_tag_q <= sel_tag_d;
      sel_par_q <= sel_par_d;
      sel_vld_q <= sel_vld_d;
    end
  end

  // g stage: final parity fold and lowest-numbered erroring way
  always_comb begin
    first_way  = '0;
    first_ptag = '0;
    for (int w = 0; w < WAYS; w++) begin
      perr[w] = rd_vld_q & vld_q[w] & ((^grp_par_q[w]) ^ par_q[w]);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (perr[w]) begin
        first_way  = WAYW'(w);
        first_ptag = {par_q[w], tag_q[w]};
      end
    end
    any_err   = |perr;
    multi_err = (perr & (perr - WAYS'(1))) != '0;
  end

  assign lsu_rd_dtag_parity_g = perr;

  // error log next state: err_clr is applied first so a coincident error logs into a clean state
  always_comb begin
    est_d   = err_clr ? E_CLEAN : est_q;
    multi_d = err_clr ? 1'b0 : multi_q;
    way_d   = err_clr ? '0 : way_q;
    ptag_d  = err_clr ? '0 : ptag_q;
    cnt_d   = err_clr ? '0 : cnt_q;
    if (any_err) begin
      if (est_d == E_CLEAN) begin
        est_d   = E_LOGGED;
        way_d   = first_way;
        ptag_d  = first_ptag;
        multi_d = multi_err;
      end else begin
        multi_d = 1'b1;
      end
      if (cnt_d != {CNTW{1'b1}}) cnt_d = cnt_d + CNTW'(1);
    end
  end

  // error log and counter registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      est_q   <= E_CLEAN;
      multi_q <= 1'b0;
      way_q   <= '0;
      ptag_q  <= '0;
      cnt_q   <= '0;
    end else begin
      est_q   <= est_d;
      multi_q <= multi_d;
      way_q   <= way_d;
      ptag_q  <= ptag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tag_perr_vld   = (est_q == E_LOGGED);
  assign tag_perr_multi = multi_q;
  assign tag_perr_way   = way_q;

  // diagnostic source mux over g-stage and log state
  always_comb begin
    case (dsel_q)
      2'd0:    diag_src = 64'({sel_par_q, sel_tag_q, sel_vld_q});
      2'd1:    diag_src = 64'({multi_q, est_q == E_LOGGED, way_q, ptag_q});
      2'd2:    diag_src = 64'(cnt_q);
      default: diag_src = '0;
    endcase
  end

  // diagnostic FSM next state; requests outside D_IDLE are ignored
  always_comb begin
    dst_d   = dst_q;
    dsel_d  = dsel_q;
    rdata_d = rdata_q;
    case (dst_q)
      D_IDLE: begin
        if (diag_req) begin
          dsel_d = diag_sel;
          dst_d  = D_MUX;
        end
      end
      D_MUX: begin
        rdata_d = diag_src;
        dst_d   = D_ACK;
      end
      D_ACK:   dst_d = D_IDLE;
      default: dst_d = D_IDLE;
    endcase
  end

  // diagnostic FSM and w2 data registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      dst_q   <= D_IDLE;
      dsel_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      dst_q   <= dst_d;
      dsel_q  <= dsel_d;
      rdata_q <= rdata_d;
    end
  end

  assign diag_busy  = (dst_q == D_MUX);
  assign diag_ack   = (dst_q == D_ACK);
  assign diag_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_tagdp_par.sv
// Bench for lsu_tagdp_par: two instances (4-way/29-bit/CNTW=8 and
// 8-way/40-bit/CNTW=2) driven in lockstep and compared every cycle against
// a plain-arithmetic reference model, plus directed scenario checks.
module tb_lsu_tagdp_par;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic              arst_l;
  logic [4*30-1:0]   rdata_a;
  logic [3:0]        dva_a, rsel_a;
  logic [8*41-1:0]   rdata_b;
  logic [7:0]        dva_b, rsel_b;
  logic              rd_vld, err_clr, dreq;
  logic [1:0]        dsel;

  logic              busy_a, ack_a, pv_a, pm_a;
  logic [63:0]       drd_a;
  logic [3:0]        par_a;
  logic [1:0]        pw_a;
  logic              busy_b, ack_b, pv_b, pm_b;
  logic [63:0]       drd_b;
  logic [7:0]        par_b;
  logic [2:0]        pw_b;

  lsu_tagdp_par #(.WAYS(4), .TAGW(29), .PGRP(8), .CNTW(8)) dut_a (
    .rclk(rclk), .arst_l(arst_l), .dtag_rdata_m(rdata_a), .dva_vld_m(dva_a),
    .lsu_dtag_rsel_m(rsel_a), .tag_rd_vld_m(rd_vld), .err_clr(err_clr),
    .diag_req(dreq), .diag_sel(dsel), .diag_busy(busy_a), .diag_ack(ack_a),
    .diag_rdata(drd_a), .lsu_rd_dtag_parity_g(par_a), .tag_perr_vld(pv_a),
    .tag_perr_multi(pm_a), .tag_perr_way(pw_a));

  lsu_tagdp_par #(.WAYS(8), .TAGW(40), .PGRP(6), .CNTW(2)) dut_b (
    .rclk(rclk), .arst_l(arst_l), .dtag_rdata_m(rdata_b), .dva_vld_m(dva_b),
    .lsu_dtag_rsel_m(rsel_b), .tag_rd_vld_m(rd_vld), .err_clr(err_clr),
    .diag_req(dreq), .diag_sel(dsel), .diag_busy(busy_b), .diag_ack(ack_b),
    .diag_rdata(drd_b), .lsu_rd_dtag_parity_g(par_b), .tag_perr_vld(pv_b),
    .tag_perr_multi(pm_b), .tag_perr_way(pw_b));

  int NW[2] = '{4, 8};
  int TW[2] = '{29, 40};
  int CW[2] = '{8, 2};
  int WW[2] = '{2, 3};

  bit [47:0] c_tag[2][8], g_tag[2][8];
  bit        c_par[2][8], g_par[2][8];
  bit        c_vld[2][8], g_vld[2][8];
  bit        c_rsel[2][8], g_rsel[2][8];
  bit        g_rdvld[2];
  bit        l_vld[2], l_multi[2];
  int        l_way[2], l_cnt[2];
  bit [48:0] l_ptag[2];
  bit [63:0] d_rd[2];
  int        ack_cyc, d_sel, cyc;
  int        n_assert, n_fail;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_perr(int k);
    logic [7:0] e = '0;
    for (int w = 0; w < NW[k]; w++)
      e[w] = g_rdvld[k] & g_vld[k][w] & ((^g_tag[k][w]) ^ g_par[k][w]);
    return e;
  endfunction

  function automatic logic [63:0] src(int k, int sel);
    logic [63:0] v = '0;
    case (sel)
      0: for (int w = 0; w < NW[k]; w++)
           if (g_rsel[k][w])
             v |= (64'(g_par[k][w]) << (TW[k] + 1)) | (64'(g_tag[k][w]) << 1) | 64'(g_vld[k][w]);
      1: v = 64'(l_ptag[k]) | (64'(l_way[k]) << (TW[k] + 1)) |
             (64'(l_vld[k]) << (TW[k] + 1 + WW[k])) | (64'(l_multi[k]) << (TW[k] + 2 + WW[k]));
      2: v = 64'(l_cnt[k]);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) begin
        g_tag[k][w] = '0; g_par[k][w] = 0; g_vld[k][w] = 0; g_rsel[k][w] = 0;
      end
      g_rdvld[k] = 0; l_vld[k] = 0; l_multi[k] = 0; l_way[k] = 0;
      l_cnt[k] = 0; l_ptag[k] = '0; d_rd[k] = '0;
    end
    ack_cyc = -1;
  endtask

  task automatic model_update();
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_perr(k);
      if (cyc == ack_cyc - 1) d_rd[k] = src(k, d_sel);
      if (err_clr) begin
        l_vld[k] = 0; l_multi[k] = 0; l_way[k] = 0; l_ptag[k] = '0; l_cnt[k] = 0;
      end
      if (e != 0) begin
        if (!l_vld[k]) begin
          l_vld[k] = 1;
          for (int w = NW[k] - 1; w >= 0; w--)
            if (e[w]) begin
              l_way[k]  = w;
              l_ptag[k] = (49'(g_par[k][w]) << TW[k]) | 49'(g_tag[k][w]);
            end
          l_multi[k] = ($countones(e) >= 2);
        end else begin
          l_multi[k] = 1;
        end
        if (l_cnt[k] < (1 << CW[k]) - 1) l_cnt[k]++;
      end
    end
    if (dreq && cyc > ack_cyc) begin
      ack_cyc = cyc + 2;
      d_sel   = int'(dsel);
    end
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) begin
        g_tag[k][w] = c_tag[k][w]; g_par[k][w] = c_par[k][w];
        g_vld[k][w] = c_vld[k][w]; g_rsel[k][w] = c_rsel[k][w];
      end
      g_rdvld[k] = rd_vld;
    end
    cyc++;
  endtask

  task automatic check_all();
    bit eb, ea;
    eb = (cyc == ack_cyc - 1);
    ea = (cyc == ack_cyc);
    chk("perr_a", 64'(par_a), 64'(exp_perr(0)));
    chk("perr_b", 64'(par_b), 64'(exp_perr(1)));
    chk("pvld_a", 64'(pv_a), 64'(l_vld[0]));
    chk("pvld_b", 64'(pv_b), 64'(l_vld[1]));
    chk("multi_a", 64'(pm_a), 64'(l_multi[0]));
    chk("multi_b", 64'(pm_b), 64'(l_multi[1]));
    chk("way_a", 64'(pw_a), 64'(l_way[0]));
    chk("way_b", 64'(pw_b), 64'(l_way[1]));
    chk("busy_a", 64'(busy_a), 64'(eb));
    chk("busy_b", 64'(busy_b), 64'(eb));
    chk("ack_a", 64'(ack_a), 64'(ea));
    chk("ack_b", 64'(ack_b), 64'(ea));
    chk("rdata_a", drd_a, d_rd[0]);
    chk("rdata_b", drd_b, d_rd[1]);
  endtask

  task automatic pack();
    for (int w = 0; w < 4; w++) begin
      rdata_a[w*30 +: 30] = {c_par[0][w], c_tag[0][w][28:0]};
      dva_a[w] = c_vld[0][w]; rsel_a[w] = c_rsel[0][w];
    end
    for (int w = 0; w < 8; w++) begin
      rdata_b[w*41 +: 41] = {c_par[1][w], c_tag[1][w][39:0]};
      dva_b[w] = c_vld[1][w]; rsel_b[w] = c_rsel[1][w];
    end
  endtask

  task automatic step();
    pack();
    @(negedge rclk);
    check_all();
    @(posedge rclk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 8; w++) begin
        c_tag[k][w] = '0; c_par[k][w] = 0; c_vld[k][w] = 0; c_rsel[k][w] = 0;
      end
    rd_vld = 0; err_clr = 0; dreq = 0; dsel = 2'd0;
  endtask

  task automatic set_way(int k, int w, bit [47:0] t, bit p, bit v);
    c_tag[k][w] = t; c_par[k][w] = p; c_vld[k][w] = v;
  endtask

  task automatic set_both(int w, bit [47:0] t, bit p, bit v);
    set_way(0, w, t, p, v);
    set_way(1, w, t, p, v);
  endtask

  task automatic diag_read(int sel);
    dreq = 1; dsel = 2'(sel);
    step();
    dreq = 0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit [47:0] msk;
    n_assert = 0; n_fail = 0; cyc = 0; d_sel = 0;
    clear_inputs();
    pack();
    arst_l = 0;
    model_reset();
    #12;
    check_all();
    chk("rst_perr_a", 64'(par_a), 64'h0);
    chk("rst_rdata_a", drd_a, 64'h0);
    @(posedge rclk); #1;
    arst_l = 1;

    // single error on way 2
    set_both(2, 48'h1, 0, 1); rd_vld = 1;
    step();
    chk("t1_perr_a", 64'(par_a), 64'h4);
    chk("t1_perr_b", 64'(par_b), 64'h4);
    clear_inputs();
    step();
    chk("t1_way_a", 64'(pw_a), 64'd2);
    diag_read(2);
    chk("t1_cnt_a", drd_a, 64'd1);

    // masked by dva_vld, then by tag_rd_vld
    set_both(2, 48'h1, 0, 0); rd_vld = 1;
    step();
    chk("t2_novld", 64'(par_a), 64'h0);
    set_both(2, 48'h1, 0, 1); rd_vld = 0;
    step();
    chk("t2_nord", 64'(par_a), 64'h0);
    clear_inputs();
    step();
    diag_read(2);
    chk("t2_cnt_a", drd_a, 64'd1);

    // two ways in one cycle, then a later way-0 error
    err_clr = 1; step(); err_clr = 0;
    set_both(1, 48'h1, 0, 1); set_both(3, 48'h1, 0, 1); rd_vld = 1;
    step();
    clear_inputs();
    step();
    chk("t3_way_a", 64'(pw_a), 64'd1);
    chk("t3_multi_a", 64'(pm_a), 64'd1);
    set_both(0, 48'h7, 0, 1); rd_vld = 1;
    step();
    clear_inputs();
    step();
    chk("t3_way2_a", 64'(pw_a), 64'd1);
    diag_read(2);
    chk("t3_cnt_a", drd_a, 64'd2);
    diag_read(1);

    // five error cycles saturate the 2-bit counter
    set_both(0, 48'h1, 0, 1); rd_vld = 1;
    for (int i = 0; i < 5; i++) step();
    clear_inputs();
    step();
    diag_read(2);
    chk("t4_sat_b", drd_b, 64'd3);
    chk("t4_cnt_a", drd_a, 64'd7);

    // err_clr coinciding with a new error
    set_both(0, 48'h1, 0, 1); rd_vld = 1;
    step();
    clear_inputs(); err_clr = 1;
    step();
    err_clr = 0;
    step();
    chk("t5_vld_a", 64'(pv_a), 64'd1);
    chk("t5_multi_a", 64'(pm_a), 64'd0);
    diag_read(2);
    chk("t5_cnt_a", drd_a, 64'd1);
    chk("t5_cnt_b", drd_b, 64'd1);

    // selected-tag read; second request during D_MUX is dropped
    set_both(3, 48'h1ABCDEF0, 1, 1);
    c_rsel[0][3] = 1; c_rsel[1][3] = 1;
    step();
    dreq = 1; dsel = 2'd0;
    step();
    step();
    dreq = 0;
    step();
    chk("t6_rdata_a", drd_a, {33'h0, 1'b1, 29'h1ABCDEF0, 1'b1});
    step();
    step();
    chk("t6_drop_a", 64'(ack_a), 64'd0);

    // reset asserted while in D_MUX
    dreq = 1; dsel = 2'd2;
    step();
    dreq = 0;
    pack();
    @(negedge rclk);
    check_all();
    arst_l = 0;
    model_reset();
    #1;
    check_all();
    chk("t7_busy_a", 64'(busy_a), 64'd0);
    chk("t7_pvld_a", 64'(pv_a), 64'd0);
    @(posedge rclk); #1;
    arst_l = 1;
    step();
    step();
    chk("t7_noack_a", 64'(ack_a), 64'd0);

    // 8-way instance, error on a way beyond the 4-way range
    clear_inputs();
    set_way(1, 6, 48'h1, 0, 1); rd_vld = 1;
    step();
    chk("t8_perr_b", 64'(par_b), 64'h40);
    clear_inputs();
    step();
    chk("t8_way_b", 64'(pw_b), 64'd6);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        msk = (48'd1 << TW[k]) - 48'd1;
        for (int w = 0; w < NW[k]; w++) begin
          c_tag[k][w]  = {$urandom, $urandom} & msk;
          c_par[k][w]  = 1'($urandom % 2);
          c_vld[k][w]  = 1'($urandom % 2);
          c_rsel[k][w] = ($urandom % 3 == 0);
        end
      end
      rd_vld  = 1'($urandom % 2);
      err_clr = ($urandom % 8 == 0);
      dreq    = ($urandom % 3 == 0);
      dsel    = 2'($urandom % 4);
      step();
    end
    clear_inputs();
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
